// File: rtl/rename_register_file.sv
// Rename register file: per-register {valid, tag, data} with same-cycle forwarding on combinational reads.
// Latency: reads 0 cycles, updates visible after the next edge; no backpressure, every strobe is accepted.
module rename_register_file #(
  parameter int REG_WIDTH = 6,
  parameter int ROB_WIDTH = 4,
  parameter int ISSUE_W   = 2,
  parameter int COMMIT_W  = 2,
  parameter int ZERO_REG  = 0,
  parameter int BYPASS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_WIDTH-1:0] src             [ISSUE_W][2],
  input  logic [REG_WIDTH-1:0] dst             [ISSUE_W],
  input  logic                 issue           [ISSUE_W],
  input  logic [ROB_WIDTH-1:0] issue_tag       [ISSUE_W],
  input  logic                 commit          [COMMIT_W],
  input  logic [REG_WIDTH-1:0] commit_arch_num [COMMIT_W],
  input  logic [ROB_WIDTH-1:0] commit_tag      [COMMIT_W],
  input  logic [31:0]          commit_data     [COMMIT_W],
  input  logic                 flush,
  output logic [ROB_WIDTH+32:0] read           [ISSUE_W][2]
);

  localparam int NREGS = 1 << REG_WIDTH;

  typedef struct packed {
    logic                 valid;
    logic [ROB_WIDTH-1:0] tag;
    logic [31:0]          data;
  } entry_t;

  localparam entry_t IDLE_ENTRY = '{valid: 1'b1, tag: '0, data: '0};

  entry_t ent [NREGS];
  entry_t nxt [NREGS];
  entry_t rd  [ISSUE_W][2];

  // Loops run in slot order so the youngest commit/issue overrides older ones.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      nxt[r] = ent[r];
      for (int c = 0; c < COMMIT_W; c++) begin
        if (commit[c] && commit_arch_num[c] == REG_WIDTH'(r)) begin
          nxt[r].data = commit_data[c];
          if (!ent[r].valid && commit_tag[c] == ent[r].tag) nxt[r].valid = 1'b1;
        end
      end
      if (flush) begin
        nxt[r].valid = 1'b1;
      end else begin
        for (int i = 0; i < ISSUE_W; i++) begin
          if (issue[i] && dst[i] == REG_WIDTH'(r)) begin
            nxt[r].valid = 1'b0;
            nxt[r].tag   = issue_tag[i];
          end
        end
      end
      if (ZERO_REG != 0 && r == 0) nxt[r] = IDLE_ENTRY;
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < NREGS; r++) begin
      if (reset) ent[r] <= IDLE_ENTRY;
      else       ent[r] <= nxt[r];
    end
  end

  // Intra-group forwarding is applied after bypass so it takes precedence.
  always_comb begin
    for (int i = 0; i < ISSUE_W; i++) begin
      for (int s = 0; s < 2; s++) begin
        rd[i][s] = ent[src[i][s]];
        if (BYPASS != 0 && !ent[src[i][s]].valid) begin
          for (int c = 0; c < COMMIT_W; c++) begin
            if (commit[c] && commit_tag[c] == ent[src[i][s]].tag) begin
              rd[i][s].valid = 1'b1;
              rd[i][s].data  = commit_data[c];
            end
          end
        end
        for (int k = 0; k < ISSUE_W; k++) begin
          if (k < i && issue[k] && dst[k] == src[i][s]) begin
            rd[i][s].valid = 1'b0;
            rd[i][s].tag   = issue_tag[k];
          end
        end
        if (ZERO_REG != 0 && src[i][s] == '0) rd[i][s] = IDLE_ENTRY;
        read[i][s] = rd[i][s];
      end
    end
  end

endmodule

// File: tb/tb_rename_register_file.sv
// Bench for rename_register_file (ZERO_REG=1): directed scenarios then random traffic
// checked against an array-based reference model of the register state.
module tb_rename_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  src [2][2];
  logic [5:0]  dst [2];
  logic        issue [2];
  logic [3:0]  issue_tag [2];
  logic        commit [2];
  logic [5:0]  commit_arch_num [2];
  logic [3:0]  commit_tag [2];
  logic [31:0] commit_data [2];
  logic        flush;
  logic [36:0] read [2][2];

  int total = 0;
  int bad   = 0;

  bit          m_valid [64];
  logic [3:0]  m_tag   [64];
  logic [31:0] m_data  [64];

  rename_register_file #(
    .REG_WIDTH(6), .ROB_WIDTH(4), .ISSUE_W(2), .COMMIT_W(2), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk(clk), .reset(reset), .src(src), .dst(dst), .issue(issue), .issue_tag(issue_tag),
    .commit(commit), .commit_arch_num(commit_arch_num), .commit_tag(commit_tag),
    .commit_data(commit_data), .flush(flush), .read(read)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic idle();
    reset = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      issue[i] = 1'b0; dst[i] = '0; issue_tag[i] = '0;
      src[i][0] = '0; src[i][1] = '0;
      commit[i] = 1'b0; commit_arch_num[i] = '0; commit_tag[i] = '0; commit_data[i] = '0;
    end
  endtask

  // Expected read of register r by slot i, straight from the forwarding rules.
  task automatic exp_read(input int i, input int r, output bit v, output logic [3:0] t,
                          output logic [31:0] d);
    bit done;
    done = 0;
    v = m_valid[r]; t = m_tag[r]; d = m_data[r];
    if (r == 0) begin
      v = 1; t = '0; d = '0; done = 1;
    end
    for (int k = i - 1; k >= 0 && !done; k--) begin
      if (issue[k] && int'(dst[k]) == r) begin
        v = 0; t = issue_tag[k]; d = '0; done = 1;
      end
    end
    if (!done && !m_valid[r]) begin
      for (int c = 1; c >= 0 && !done; c--) begin
        if (commit[c] && commit_tag[c] == m_tag[r]) begin
          v = 1; d = commit_data[c]; done = 1;
        end
      end
    end
  endtask

  task automatic check_all(input string name);
    bit v; logic [3:0] t; logic [31:0] d;
    for (int i = 0; i < 2; i++) begin
      for (int s = 0; s < 2; s++) begin
        exp_read(i, int'(src[i][s]), v, t, d);
        chk({name, "_valid"}, 32'(read[i][s][36]), 32'(v));
        if (v) chk({name, "_data"}, read[i][s][31:0], d);
        else   chk({name, "_tag"}, 32'(read[i][s][35:32]), 32'(t));
      end
    end
  endtask

  task automatic model_step();
    bit          nv [64];
    logic [3:0]  nt [64];
    logic [31:0] nd [64];
    int          youngest;
    bit          tag_hit;
    for (int r = 0; r < 64; r++) begin
      nv[r] = m_valid[r]; nt[r] = m_tag[r]; nd[r] = m_data[r];
    end
    for (int r = 1; r < 64; r++) begin
      youngest = -1;
      tag_hit  = 0;
      for (int c = 0; c < 2; c++) begin
        if (commit[c] && int'(commit_arch_num[c]) == r) begin
          nd[r] = commit_data[c];
          if (commit_tag[c] == m_tag[r]) tag_hit = 1;
        end
      end
      if (!flush)
        for (int i = 0; i < 2; i++)
          if (issue[i] && int'(dst[i]) == r) youngest = i;
      if (youngest >= 0) begin
        nv[r] = 0; nt[r] = issue_tag[youngest];
      end else if (flush || (!m_valid[r] && tag_hit)) begin
        nv[r] = 1;
      end
    end
    for (int r = 0; r < 64; r++) begin
      m_valid[r] = reset ? 1'b1 : nv[r];
      m_tag[r]   = reset ? 4'h0 : nt[r];
      m_data[r]  = reset ? 32'h0 : nd[r];
    end
  endtask

  task automatic next();
    @(posedge clk);
    model_step();
    @(negedge clk);
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    next();

    // Reset state
    src[0][0] = 6'd5;
    #1;
    chk("rst_r5_valid", 32'(read[0][0][36]), 32'd1);
    chk("rst_r5_data", read[0][0][31:0], 32'd0);
    check_all("rst");
    next();

    // Issue r3/tag7, then commit with bypass
    issue[0] = 1'b1; dst[0] = 6'd3; issue_tag[0] = 4'd7;
    #1 check_all("iss3");
    next();
    commit[0] = 1'b1; commit_arch_num[0] = 6'd3; commit_tag[0] = 4'd7;
    commit_data[0] = 32'hDEADBEEF; src[0][0] = 6'd3;
    #1;
    chk("bypass_valid", 32'(read[0][0][36]), 32'd1);
    chk("bypass_data", read[0][0][31:0], 32'hDEADBEEF);
    check_all("bypass");
    next();
    src[0][0] = 6'd3;
    #1;
    chk("stored_valid", 32'(read[0][0][36]), 32'd1);
    chk("stored_data", read[0][0][31:0], 32'hDEADBEEF);
    next();

    // Intra-group forwarding and youngest-issue-wins
    issue[0] = 1'b1; dst[0] = 6'd4; issue_tag[0] = 4'd2;
    issue[1] = 1'b1; dst[1] = 6'd4; issue_tag[1] = 4'd3; src[1][0] = 6'd4;
    #1;
    chk("fwd_valid", 32'(read[1][0][36]), 32'd0);
    chk("fwd_tag", 32'(read[1][0][35:32]), 32'd2);
    check_all("fwd");
    next();
    src[0][0] = 6'd4;
    commit[0] = 1'b1; commit_arch_num[0] = 6'd4; commit_tag[0] = 4'd2; commit_data[0] = 32'h1234;
    #1;
    chk("r4_tag", 32'(read[0][0][35:32]), 32'd3);
    chk("r4_valid", 32'(read[0][0][36]), 32'd0);
    next();
    src[0][0] = 6'd4;
    #1;
    chk("stale_valid", 32'(read[0][0][36]), 32'd0);
    chk("stale_tag", 32'(read[0][0][35:32]), 32'd3);
    next();
    flush = 1'b1;
    next();
    src[0][0] = 6'd4;
    #1 chk("stale_data", read[0][0][31:0], 32'h1234);
    next();

    // Issue and commit to r6 in one cycle
    issue[0] = 1'b1; dst[0] = 6'd6; issue_tag[0] = 4'd1;
    commit[1] = 1'b1; commit_arch_num[1] = 6'd6; commit_tag[1] = 4'd0; commit_data[1] = 32'h55;
    next();
    src[0][0] = 6'd6;
    #1;
    chk("r6_valid", 32'(read[0][0][36]), 32'd0);
    chk("r6_tag", 32'(read[0][0][35:32]), 32'd1);
    flush = 1'b1;
    next();
    src[0][0] = 6'd6;
    #1 chk("r6_data", read[0][0][31:0], 32'h55);
    next();

    // Flush with a commit; issues in the flush cycle dropped
    commit[0] = 1'b1; commit_arch_num[0] = 6'd2; commit_data[0] = 32'h22;
    next();
    issue[0] = 1'b1; dst[0] = 6'd1; issue_tag[0] = 4'd5;
    issue[1] = 1'b1; dst[1] = 6'd2; issue_tag[1] = 4'd6;
    next();
    flush = 1'b1; commit[0] = 1'b1; commit_arch_num[0] = 6'd1; commit_data[0] = 32'd9;
    src[0][0] = 6'd1; src[0][1] = 6'd2;
    #1 check_all("flush");
    next();
    src[0][0] = 6'd1; src[0][1] = 6'd2;
    #1;
    chk("flush_r1_valid", 32'(read[0][0][36]), 32'd1);
    chk("flush_r1_data", read[0][0][31:0], 32'd9);
    chk("flush_r2_valid", 32'(read[0][1][36]), 32'd1);
    chk("flush_r2_data", read[0][1][31:0], 32'h22);
    next();
    issue[0] = 1'b1; dst[0] = 6'd8; issue_tag[0] = 4'd3; flush = 1'b1;
    next();
    src[0][0] = 6'd8;
    #1 chk("flush_drop_issue", 32'(read[0][0][36]), 32'd1);
    next();

    // Hardwired zero register
    issue[0] = 1'b1; dst[0] = 6'd0; issue_tag[0] = 4'd9;
    commit[0] = 1'b1; commit_arch_num[0] = 6'd0; commit_data[0] = 32'hFF; src[1][0] = 6'd0;
    #1;
    chk("r0_same_valid", 32'(read[1][0][36]), 32'd1);
    chk("r0_same_data", read[1][0][31:0], 32'd0);
    next();
    src[0][0] = 6'd0;
    #1;
    chk("r0_valid", 32'(read[0][0][36]), 32'd1);
    chk("r0_data", read[0][0][31:0], 32'd0);
    next();

    // Reset discards outstanding issues
    issue[0] = 1'b1; dst[0] = 6'd7; issue_tag[0] = 4'd4;
    next();
    reset = 1'b1;
    next();
    commit[0] = 1'b1; commit_arch_num[0] = 6'd7; commit_tag[0] = 4'd4;
    commit_data[0] = 32'h77; src[0][0] = 6'd7;
    #1;
    chk("rst_discard_valid", 32'(read[0][0][36]), 32'd1);
    chk("rst_discard_data", read[0][0][31:0], 32'd0);
    next();
    src[0][0] = 6'd7;
    #1 chk("rst_late_commit", read[0][0][31:0], 32'h77);
    next();

    // Random traffic over a few registers to force collisions
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        issue[i]     = 1'($urandom_range(0, 1));
        dst[i]       = 6'($urandom_range(0, 7));
        issue_tag[i] = 4'($urandom_range(0, 15));
        src[i][0]    = 6'($urandom_range(0, 7));
        src[i][1]    = 6'($urandom_range(0, 7));
        commit[i]          = 1'($urandom_range(0, 1));
        commit_arch_num[i] = 6'($urandom_range(0, 7));
        commit_tag[i]      = ($urandom_range(0, 1) == 1) ? m_tag[commit_arch_num[i]]
                                                         : 4'($urandom_range(0, 15));
        commit_data[i]     = $urandom;
      end
      flush = ($urandom_range(0, 19) == 0);
      reset = ($urandom_range(0, 59) == 0);
      #1 check_all("rnd");
      next();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rename_register_file.md
RENAME_REGISTER_FILE -- requirements
Module: rename_register_file

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 6, log2 of the architectural register count.
REQ-002 SHALL have parameter ROB_WIDTH, default 4, width of a ROB tag.
REQ-003 SHALL have parameter ISSUE_W, default 2, issue slots per cycle; slot index order equals program order.
REQ-004 SHALL have parameter COMMIT_W, default 2, commit slots per cycle; slot index order equals program order.
REQ-005 SHALL have parameter ZERO_REG, default 0; when 1, register 0 is hardwired to zero.
REQ-006 SHALL have parameter BYPASS, default 1; when 1, same-cycle commit data is forwarded to the read ports.
REQ-007 clk  input  1  sole clock, rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 src[ISSUE_W][2]  input  REG_WIDTH  source register numbers, per slot.
REQ-010 dst[ISSUE_W]  input  REG_WIDTH  destination register, per slot.
REQ-011 issue[ISSUE_W]  input  1  the slot allocates dst.
REQ-012 issue_tag[ISSUE_W]  input  ROB_WIDTH  ROB tag given to the slot.
REQ-013 commit[COMMIT_W]  input  1  commit strobe, per slot.
REQ-014 commit_arch_num[COMMIT_W]  input  REG_WIDTH  committed architectural register.
REQ-015 commit_tag[COMMIT_W]  input  ROB_WIDTH  committed ROB tag.
REQ-016 commit_data[COMMIT_W]  input  32  committed value.
REQ-017 flush  input  1  misprediction recovery.
REQ-018 read[ISSUE_W][2]  output  1+ROB_WIDTH+32  {valid, tag, data} per source.

Function
REQ-019 Each entry SHALL hold valid, tag and data; valid=1 means data is current, valid=0 means the value is pending on tag.
REQ-020 Reads SHALL be combinational from the current state; there SHALL be no read latency.
REQ-021 Intra-group forwarding SHALL apply: if slot j>0 reads register r and an older slot k<j issues to r in the same cycle, the read SHALL return valid=0 with tag=issue_tag[k] of the youngest such k.
REQ-022 Commit bypass SHALL apply when BYPASS=1 and REQ-021 does not: if the entry is pending and a commit slot has commit_tag equal to the entry tag, the read SHALL return valid=1 with that commit_data.
REQ-023 On issue[i] SHALL set entry dst[i] to valid=0, tag=issue_tag[i] at the next edge.
REQ-024 When several slots issue to one register, the youngest slot's tag SHALL win.
REQ-025 On commit[c] SHALL write commit_data[c] into entry commit_arch_num[c].data, whatever the entry's valid value.
REQ-026 When several commits target one register, the youngest commit slot's data SHALL win.
REQ-027 On commit[c] SHALL set valid=1 only when the entry is pending, its tag equals commit_tag[c], and no issue targets that register in the same cycle.
REQ-028 Issue and commit to the same register in one cycle SHALL give valid=0, tag=new issue tag, data=commit_data.
REQ-029 A commit whose tag does not match a pending entry SHALL update data only.
REQ-030 On flush SHALL set valid=1 in all entries; tags and data SHALL be kept.
REQ-031 Commits in the flush cycle SHALL still write data.
REQ-032 Issues in the flush cycle SHALL be ignored.
REQ-033 When ZERO_REG=1, register 0 SHALL always read valid=1, data=0, and SHALL ignore issue and commit.

Reset
REQ-034 On reset SHALL set every entry to valid=1, tag=0, data=0 at the next edge.
REQ-035 Reset SHALL take priority over flush, issue and commit.
REQ-036 Reset asserted during outstanding issues SHALL discard them; a later commit of a discarded tag SHALL update data only.
REQ-037 Read outputs after reset SHALL be valid=1, data=0 for all registers.

Verification
REQ-038 Reset, then read r5 -> valid=1, data=0.
REQ-039 Slot0 issues r3 with tag 7; next cycle commit tag 7, arch 3, data 0xDEADBEEF -> in the commit cycle r3 reads valid=1, 0xDEADBEEF (bypass); the next cycle the stored value is the same.
REQ-040 Same cycle: slot0 issues r4 with tag 2; slot1 reads r4 and issues r4 with tag 3 -> slot1 read gives valid=0, tag=2; the next cycle r4 has tag=3; a commit of tag 2 leaves r4 valid=0 and writes data.
REQ-041 Issue r6 with tag 1 and commit (arch 6, tag 0, data 0x55) in the same cycle -> r6 valid=0, tag=1, data=0x55.
REQ-042 Issue r1, r2, then flush together with a commit (arch 1, data 9) -> all entries valid; r1 data=9; r2 data unchanged.
REQ-043 ZERO_REG=1: issue r0 and commit arch 0 with data 0xFF -> r0 reads valid=1, data=0.
